// File: rtl/dummy_mc_pkg.sv
// Shared constants and response-entry layout for the dummy multi-port MC model.
package dummy_mc_pkg;

    localparam logic [2:0] MC_CMD_RD     = 3'd1;
    localparam logic [2:0] MC_CMD_WR     = 3'd2;
    localparam logic [2:0] MC_RS_RD_DATA = 3'd2;
    localparam logic [2:0] MC_RS_WR_CMP  = 3'd3;
    localparam logic [1:0] MC_SIZE_8B    = 2'd3;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [63:0] data;
    } rsp_base_t;

    localparam int unsigned RSP_BASE_W = $bits(rsp_base_t);

    // Full entry is {rtnctl, rsp_base_t}.
    function automatic int unsigned rsp_entry_width(input int unsigned rtnctl_w);
        return rtnctl_w + RSP_BASE_W;
    endfunction

endpackage

// File: rtl/dummy_mc_port.sv
// One MC port: request check/accept, latency pipeline, response FIFO, head register and stall.
// Optional DUMMY_MC_RAND_STALL_EN adds an LFSR that injects random rq stalls and rs holds.
module dummy_mc_port
    import dummy_mc_pkg::*;
#(
    parameter int unsigned PORT_IDX        = 0,
    parameter int unsigned MC_RTNCTL_WIDTH = 32,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned RSP_FIFO_DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rq_vld,
    input  logic [2:0]                 rq_cmd,
    input  logic [1:0]                 rq_size,
    input  logic [MC_RTNCTL_WIDTH-1:0] rq_rtnctl,
    input  logic [63:0]                rd_data,
    output logic                       rq_accept,
    output logic                       rq_drop,
    output logic                       rq_stall,
    output logic                       rs_vld,
    output logic [2:0]                 rs_cmd,
    output logic [3:0]                 rs_scmd,
    output logic [MC_RTNCTL_WIDTH-1:0] rs_rtnctl,
    output logic [63:0]                rs_data,
    input  logic                       rs_stall
);

    localparam int unsigned EW = rsp_entry_width(MC_RTNCTL_WIDTH);
    localparam int unsigned PW = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(RSP_FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(RSP_FIFO_DEPTH - 2);

    logic            cmd_ok;
    logic            is_rd;
    rsp_base_t       new_base;
    logic [EW-1:0]   new_entry;

    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [EW-1:0]      pipe_q [LATENCY];
    logic [EW-1:0]      pipe_d [LATENCY];

    logic [EW-1:0]   fifo_mem_q [RSP_FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic            push, pop;

    logic            head_vld_q, head_vld_d;
    logic [EW-1:0]   head_q, head_d;
    rsp_base_t       head_base;

    logic [CW-1:0]   out_q, out_d;
    logic            stall_q, stall_d;
    logic            rs_hs;
    logic            rand_rq_stall;
    logic            rand_hold;

    assign is_rd     = (rq_cmd == MC_CMD_RD);
    assign cmd_ok    = (is_rd || rq_cmd == MC_CMD_WR) && (rq_size == MC_SIZE_8B);
    assign rq_accept = rq_vld && cmd_ok && (out_q < FULL_CNT);
    assign rq_drop   = rq_vld && !rq_accept;

    always_comb begin
        new_base.cmd  = is_rd ? MC_RS_RD_DATA : MC_RS_WR_CMP;
        new_base.data = is_rd ? rd_data : 64'd0;
        new_entry     = {rq_rtnctl, new_base};
    end

    always_comb begin
        pipe_vld_d[0] = rq_accept;
        pipe_d[0]     = new_entry;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_d[i]     = pipe_q[i-1];
        end
    end

    // FIFO space was reserved by the outstanding counter at accept time.
    assign push  = pipe_vld_q[LATENCY-1];
    assign rs_hs = rs_vld && !rs_stall;
    assign pop   = (fifo_cnt_q != '0) && (!head_vld_q || rs_hs);

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        head_vld_d = head_vld_q;
        head_d     = head_q;
        if (pop) begin
            head_vld_d = 1'b1;
            head_d     = fifo_mem_q[rd_ptr_q];
        end else if (rs_hs) begin
            head_vld_d = 1'b0;
        end
        out_d   = out_q + CW'(rq_accept) - CW'(rs_hs);
        stall_d = (out_d >= STALL_CNT);
    end

`ifdef DUMMY_MC_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1 ^ 16'(PORT_IDX);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_rq_stall = (lfsr_q[2:0] == 3'd0);
    assign rand_hold     = (lfsr_q[5:3] == 3'd0);
`else
    assign rand_rq_stall = 1'b0;
    assign rand_hold     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
            out_q      <= '0;
            stall_q    <= 1'b0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            out_q      <= out_d;
            stall_q    <= stall_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the flops above.
    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= pipe_q[LATENCY-1];
        end
    end

    assign head_base = head_q[RSP_BASE_W-1:0];
    assign rq_stall  = stall_q || rand_rq_stall;
    assign rs_vld    = head_vld_q && !rand_hold;
    assign rs_cmd    = head_base.cmd;
    assign rs_data   = head_base.data;
    assign rs_rtnctl = head_q[EW-1 -: MC_RTNCTL_WIDTH];
    assign rs_scmd   = 4'd0;

endmodule

// File: rtl/dummy_mc_mp.sv
// Multi-port behavioural MC model: shared word RAM plus one dummy_mc_port per channel.
// Define DUMMY_MC_RAND_STALL_EN to enable per-port random stall injection.
module dummy_mc_mp
    import dummy_mc_pkg::*;
#(
    parameter int unsigned NUM_MC_PORTS    = 1,
    parameter int unsigned MC_RTNCTL_WIDTH = 32,
    parameter int unsigned RAM_DEPTH       = 512,
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned RSP_FIFO_DEPTH  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rq_vld,
    input  logic [3*NUM_MC_PORTS-1:0]               mc_rq_cmd,
    input  logic [4*NUM_MC_PORTS-1:0]               mc_rq_scmd,
    input  logic [48*NUM_MC_PORTS-1:0]              mc_rq_vadr,
    input  logic [2*NUM_MC_PORTS-1:0]               mc_rq_size,
    input  logic [MC_RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rq_rtnctl,
    input  logic [64*NUM_MC_PORTS-1:0]              mc_rq_data,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rq_flush,
    output logic [NUM_MC_PORTS-1:0]                 mc_rq_stall,
    output logic [NUM_MC_PORTS-1:0]                 mc_rs_vld,
    output logic [3*NUM_MC_PORTS-1:0]               mc_rs_cmd,
    output logic [4*NUM_MC_PORTS-1:0]               mc_rs_scmd,
    output logic [MC_RTNCTL_WIDTH*NUM_MC_PORTS-1:0] mc_rs_rtnctl,
    output logic [64*NUM_MC_PORTS-1:0]              mc_rs_data,
    input  logic [NUM_MC_PORTS-1:0]                 mc_rs_stall,
    output logic                                    err_ovf
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);

    logic [63:0]             mem_q [RAM_DEPTH];
    logic [63:0]             rd_data [NUM_MC_PORTS];
    logic [AW-1:0]           rq_idx [NUM_MC_PORTS];
    logic [NUM_MC_PORTS-1:0] rq_accept;
    logic [NUM_MC_PORTS-1:0] rq_drop;
    logic [NUM_MC_PORTS-1:0] wr_en;
    logic                    err_q, err_d;
    logic                    unused_in;

    // Flush has no data effect; sub-command and out-of-range address bits are don't-care.
    assign unused_in = ^{mc_rq_scmd, mc_rq_flush, mc_rq_vadr};

    for (genvar p = 0; p < NUM_MC_PORTS; p++) begin : g_port
        assign rq_idx[p]  = mc_rq_vadr[p*48+3 +: AW];
        assign rd_data[p] = mem_q[rq_idx[p]];
        assign wr_en[p]   = rq_accept[p] && (mc_rq_cmd[p*3 +: 3] == MC_CMD_WR);

        dummy_mc_port #(
            .PORT_IDX        (p),
            .MC_RTNCTL_WIDTH (MC_RTNCTL_WIDTH),
            .LATENCY         (LATENCY),
            .RSP_FIFO_DEPTH  (RSP_FIFO_DEPTH)
        ) u_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .rq_vld    (mc_rq_vld[p]),
            .rq_cmd    (mc_rq_cmd[p*3 +: 3]),
            .rq_size   (mc_rq_size[p*2 +: 2]),
            .rq_rtnctl (mc_rq_rtnctl[p*MC_RTNCTL_WIDTH +: MC_RTNCTL_WIDTH]),
            .rd_data   (rd_data[p]),
            .rq_accept (rq_accept[p]),
            .rq_drop   (rq_drop[p]),
            .rq_stall  (mc_rq_stall[p]),
            .rs_vld    (mc_rs_vld[p]),
            .rs_cmd    (mc_rs_cmd[p*3 +: 3]),
            .rs_scmd   (mc_rs_scmd[p*4 +: 4]),
            .rs_rtnctl (mc_rs_rtnctl[p*MC_RTNCTL_WIDTH +: MC_RTNCTL_WIDTH]),
            .rs_data   (mc_rs_data[p*64 +: 64]),
            .rs_stall  (mc_rs_stall[p])
        );
    end

    // Later loop iterations override earlier ones, so the highest port wins a write collision.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_MC_PORTS; p++) begin
            if (wr_en[p]) begin
                mem_q[rq_idx[p]] <= mc_rq_data[p*64 +: 64];
            end
        end
    end

    assign err_d = err_q || (|rq_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_ovf = err_q;

endmodule

// File: tb/tb_dummy_mc_mp.sv
// Directed self-checking bench for dummy_mc_mp with two ports and default depth/latency.
module tb_dummy_mc_mp;

    localparam logic [2:0] RD = 3'd1;
    localparam logic [2:0] WR = 3'd2;
    localparam logic [2:0] RS_RD = 3'd2;
    localparam logic [2:0] RS_WR = 3'd3;
    localparam logic [63:0] DATA0 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] DATA_WRAP = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] DATA_A = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] DATA_B = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] DATA_D = 64'hDDDD_0000_0000_000D;

    logic         clk;
    logic         rst_n;
    logic [1:0]   rq_vld;
    logic [5:0]   rq_cmd;
    logic [7:0]   rq_scmd;
    logic [95:0]  rq_vadr;
    logic [3:0]   rq_size;
    logic [63:0]  rq_rtnctl;
    logic [127:0] rq_data;
    logic [1:0]   rq_flush;
    logic [1:0]   rq_stall;
    logic [1:0]   rs_vld;
    logic [5:0]   rs_cmd;
    logic [7:0]   rs_scmd;
    logic [63:0]  rs_rtnctl;
    logic [127:0] rs_data;
    logic [1:0]   rs_stall;
    logic         err_ovf;

    int n_checks = 0;
    int n_pass = 0;

    dummy_mc_mp #(
        .NUM_MC_PORTS (2)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mc_rq_vld    (rq_vld),
        .mc_rq_cmd    (rq_cmd),
        .mc_rq_scmd   (rq_scmd),
        .mc_rq_vadr   (rq_vadr),
        .mc_rq_size   (rq_size),
        .mc_rq_rtnctl (rq_rtnctl),
        .mc_rq_data   (rq_data),
        .mc_rq_flush  (rq_flush),
        .mc_rq_stall  (rq_stall),
        .mc_rs_vld    (rs_vld),
        .mc_rs_cmd    (rs_cmd),
        .mc_rs_scmd   (rs_scmd),
        .mc_rs_rtnctl (rs_rtnctl),
        .mc_rs_data   (rs_data),
        .mc_rs_stall  (rs_stall),
        .err_ovf      (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rq(input int p, input logic [2:0] cmd, input logic [47:0] vadr,
                            input logic [31:0] tag, input logic [63:0] data,
                            input logic [1:0] size);
        rq_vld[p]             = 1'b1;
        rq_cmd[p*3 +: 3]      = cmd;
        rq_vadr[p*48 +: 48]   = vadr;
        rq_rtnctl[p*32 +: 32] = tag;
        rq_data[p*64 +: 64]   = data;
        rq_size[p*2 +: 2]     = size;
    endtask

    task automatic idle();
        rq_vld   = '0;
        rq_flush = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic expect_rsp(input int p, input string tag, input logic [2:0] cmd,
                              input logic [31:0] rtn, input logic [63:0] data);
        int i = 0;
        while (!rs_vld[p] && i < 20) begin
            tick(1);
            i++;
        end
        check_eq({tag, "_vld"}, 64'(rs_vld[p]), 64'd1);
        check_eq({tag, "_cmd"}, 64'(rs_cmd[p*3 +: 3]), 64'(cmd));
        check_eq({tag, "_rtnctl"}, 64'(rs_rtnctl[p*32 +: 32]), 64'(rtn));
        check_eq({tag, "_data"}, rs_data[p*64 +: 64], data);
        tick(1);
    endtask

    task automatic expect_quiet(input int p, input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            tick(1);
            seen = seen | rs_vld[p];
        end
        check_eq(tag, 64'(seen), 64'd0);
    endtask

    logic [9:0] stall_obs;
    logic [9:0] err_obs;
    logic       stale;

    initial begin
        rst_n = 1'b0;
        rq_vld = '0; rq_cmd = '0; rq_scmd = '0; rq_vadr = '0; rq_size = '0;
        rq_rtnctl = '0; rq_data = '0; rq_flush = '0; rs_stall = '0;
        tick(3);
        check_eq("reset_rs_vld", 64'(rs_vld), 64'd0);
        check_eq("reset_rq_stall", 64'(rq_stall), 64'd0);
        check_eq("reset_err", 64'(err_ovf), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Write then read, with exact latency.
        drive_rq(0, WR, 48'h40, 32'h11, DATA0, 2'd3);
        tick(1);
        drive_rq(0, RD, 48'h40, 32'h22, 64'd0, 2'd3);
        tick(1);
        idle();
        tick(3);
        check_eq("lat_not_yet", 64'(rs_vld[0]), 64'd0);
        tick(1);
        check_eq("lat_wr_vld", 64'(rs_vld[0]), 64'd1);
        check_eq("lat_wr_cmd", 64'(rs_cmd[2:0]), 64'(RS_WR));
        check_eq("lat_wr_rtn", 64'(rs_rtnctl[31:0]), 64'h11);
        check_eq("lat_wr_data", rs_data[63:0], 64'd0);
        check_eq("rs_scmd", 64'(rs_scmd), 64'd0);
        tick(1);
        check_eq("lat_rd_vld", 64'(rs_vld[0]), 64'd1);
        check_eq("lat_rd_cmd", 64'(rs_cmd[2:0]), 64'(RS_RD));
        check_eq("lat_rd_rtn", 64'(rs_rtnctl[31:0]), 64'h22);
        check_eq("lat_rd_data", rs_data[63:0], DATA0);
        tick(1);
        check_eq("lat_drained", 64'(rs_vld[0]), 64'd0);

        // Address wrap-around: 0x1000 maps to word 0 with 512 words.
        drive_rq(0, WR, 48'h1000, 32'h31, DATA_WRAP, 2'd3);
        tick(1);
        drive_rq(0, RD, 48'h0, 32'h32, 64'd0, 2'd3);
        tick(1);
        idle();
        expect_rsp(0, "wrap_wr", RS_WR, 32'h31, 64'd0);
        expect_rsp(0, "wrap_rd", RS_RD, 32'h32, DATA_WRAP);

        // Back-pressure: 10 reads against a stalled consumer.
        rs_stall[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_rq(0, RD, 48'h40, 32'h100 + i, 64'd0, 2'd3);
            tick(1);
            stall_obs[i] = rq_stall[0];
            err_obs[i] = err_ovf;
        end
        idle();
        check_eq("bp_stall_5", 64'(stall_obs[4]), 64'd0);
        check_eq("bp_stall_6", 64'(stall_obs[5]), 64'd1);
        check_eq("bp_err_8", 64'(err_obs[7]), 64'd0);
        check_eq("bp_err_9", 64'(err_obs[8]), 64'd1);
        tick(6);
        check_eq("bp_err_sticky", 64'(err_ovf), 64'd1);
        rs_stall[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("bp_vld", 64'(rs_vld[0]), 64'd1);
            check_eq("bp_rtn", 64'(rs_rtnctl[31:0]), 64'h100 + 64'(k));
            check_eq("bp_data", rs_data[63:0], DATA0);
            tick(1);
        end
        check_eq("bp_done", 64'(rs_vld[0]), 64'd0);
        check_eq("bp_stall_clr", 64'(rq_stall[0]), 64'd0);

        // Same-cycle collisions between ports.
        rs_stall[1] = 1'b1;
        drive_rq(0, WR, 48'h40, 32'h41, DATA_A, 2'd3);
        drive_rq(1, WR, 48'h40, 32'h51, DATA_B, 2'd3);
        tick(1);
        drive_rq(0, RD, 48'h40, 32'h42, 64'd0, 2'd3);
        drive_rq(1, WR, 48'h40, 32'h52, DATA_D, 2'd3);
        tick(1);
        idle();
        drive_rq(0, RD, 48'h40, 32'h43, 64'd0, 2'd3);
        tick(1);
        idle();
        expect_rsp(0, "col_wr0", RS_WR, 32'h41, 64'd0);
        expect_rsp(0, "col_rbw", RS_RD, 32'h42, DATA_B);
        expect_rsp(0, "col_after", RS_RD, 32'h43, DATA_D);
        rs_stall[1] = 1'b0;
        expect_rsp(1, "col_p1a", RS_WR, 32'h51, 64'd0);
        expect_rsp(1, "col_p1b", RS_WR, 32'h52, 64'd0);

        // Reset with responses in flight.
        rs_stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rq(0, RD, 48'h40, 32'h61 + i, 64'd0, 2'd3);
            tick(1);
        end
        idle();
        tick(3);
        check_eq("rst_pre_vld", 64'(rs_vld[0]), 64'd1);
        check_eq("rst_pre_rtn", 64'(rs_rtnctl[31:0]), 64'h61);
        rst_n = 1'b0;
        #1;
        check_eq("rst_vld", 64'(rs_vld), 64'd0);
        check_eq("rst_cmd", 64'(rs_cmd), 64'd0);
        check_eq("rst_rtn", rs_rtnctl, 64'd0);
        check_eq("rst_data_lo", rs_data[63:0], 64'd0);
        check_eq("rst_err", 64'(err_ovf), 64'd0);
        check_eq("rst_stall", 64'(rq_stall), 64'd0);
        rs_stall[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        expect_quiet(0, "rst_no_stale", 12);
        drive_rq(0, RD, 48'h40, 32'h70, 64'd0, 2'd3);
        tick(1);
        idle();
        expect_rsp(0, "rst_ram_keep", RS_RD, 32'h70, DATA_D);

        // Illegal command and size.
        drive_rq(0, 3'd3, 48'h40, 32'h80, 64'd0, 2'd3);
        tick(1);
        idle();
        check_eq("ill_cmd_err", 64'(err_ovf), 64'd1);
        expect_quiet(0, "ill_cmd_norsp", 10);
        check_eq("ill_cmd_stall", 64'(rq_stall[0]), 64'd0);
        do_reset();
        drive_rq(0, RD, 48'h40, 32'h81, 64'd0, 2'd2);
        tick(1);
        idle();
        check_eq("ill_size_err", 64'(err_ovf), 64'd1);
        expect_quiet(0, "ill_size_norsp", 10);

        // Flush with nothing outstanding.
        do_reset();
        rq_flush[0] = 1'b1;
        tick(1);
        idle();
        expect_quiet(0, "flush_norsp", 10);
        check_eq("flush_err", 64'(err_ovf), 64'd0);
        drive_rq(0, RD, 48'h1000, 32'h90, 64'd0, 2'd3);
        tick(1);
        idle();
        expect_rsp(0, "post_flush", RS_RD, 32'h90, DATA_WRAP);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
